multicycle_ctrl: RTL

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl
// Brief    : Control FSM for a multicycle RV32 datapath. Sequences fetch,
//            decode, execute, memory access and write-back, drives the memory,
//            PC and register-file strobes, flags illegal instruction classes
//            with a sticky trap and counts retired instructions.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_ctrl (
    input  logic        clk,
    input  logic        rst,
    // Instruction class lines from the main decoder
    input  logic        R,
    input  logic        I_L,
    input  logic        I_C,
    input  logic        JALR,
    input  logic        S,
    input  logic        B,
    input  logic        LUI,
    input  logic        AUIPC,
    input  logic        JAL,
    // Datapath / memory status
    input  logic        branch_taken,
    input  logic        mem_ready,
    // Memory and instruction register
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic        ir_we,
    // PC and register file
    output logic        pc_we,
    output logic        pc_sel,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    // Status
    output logic [2:0]  state,
    output logic        trap,
    output logic [31:0] retire_cnt
);

    // State encodings (visible on the state output)
    localparam logic [2:0] c_ST_FETCH  = 3'd0;
    localparam logic [2:0] c_ST_DECODE = 3'd1;
    localparam logic [2:0] c_ST_EXEC   = 3'd2;
    localparam logic [2:0] c_ST_MEM    = 3'd3;
    localparam logic [2:0] c_ST_WB     = 3'd4;
    localparam logic [2:0] c_ST_TRAP   = 3'd5;

    // Latched instruction class
    localparam logic [3:0] c_CLS_NONE  = 4'd0;
    localparam logic [3:0] c_CLS_R     = 4'd1;
    localparam logic [3:0] c_CLS_I_C   = 4'd2;
    localparam logic [3:0] c_CLS_I_L   = 4'd3;
    localparam logic [3:0] c_CLS_S     = 4'd4;
    localparam logic [3:0] c_CLS_B     = 4'd5;
    localparam logic [3:0] c_CLS_JALR  = 4'd6;
    localparam logic [3:0] c_CLS_JAL   = 4'd7;
    localparam logic [3:0] c_CLS_LUI   = 4'd8;
    localparam logic [3:0] c_CLS_AUIPC = 4'd9;

    // Write-back source selects
    localparam logic [1:0] c_WB_ALU    = 2'd0;
    localparam logic [1:0] c_WB_MEM    = 2'd1;
    localparam logic [1:0] c_WB_PC4    = 2'd2;

    logic [2:0]  r_state;
    logic [3:0]  r_class;
    logic        r_trap;
    logic [31:0] r_retire_cnt;

    logic [2:0]  w_next_state;
    logic [3:0]  w_decoded_class;
    logic        w_load_class;
    logic        w_set_trap;
    logic        w_mem_req;
    logic        w_mem_we;
    logic        w_addr_sel;
    logic        w_ir_we;
    logic        w_pc_we;
    logic        w_pc_sel;
    logic        w_rf_we;
    logic [1:0]  w_wb_sel;

    // Priority-encode the decoder class lines; only consumed in DECODE
    always_comb begin
        w_decoded_class = c_CLS_NONE;
        if (R)          w_decoded_class = c_CLS_R;
        else if (I_C)   w_decoded_class = c_CLS_I_C;
        else if (I_L)   w_decoded_class = c_CLS_I_L;
        else if (S)     w_decoded_class = c_CLS_S;
        else if (B)     w_decoded_class = c_CLS_B;
        else if (JALR)  w_decoded_class = c_CLS_JALR;
        else if (JAL)   w_decoded_class = c_CLS_JAL;
        else if (LUI)   w_decoded_class = c_CLS_LUI;
        else if (AUIPC) w_decoded_class = c_CLS_AUIPC;
    end

    // Next-state and strobe generation; every strobe defaults low
    always_comb begin
        w_next_state = r_state;
        w_load_class = 1'b0;
        w_set_trap   = 1'b0;
        w_mem_req    = 1'b0;
        w_mem_we     = 1'b0;
        w_addr_sel   = 1'b0;
        w_ir_we      = 1'b0;
        w_pc_we      = 1'b0;
        w_pc_sel     = 1'b0;
        w_rf_we      = 1'b0;
        w_wb_sel     = c_WB_ALU;
        case (r_state)
            c_ST_FETCH: begin
                // Instruction fetch from PC; IR loads on the completing cycle
                w_mem_req = 1'b1;
                if (mem_ready) begin
                    w_ir_we      = 1'b1;
                    w_next_state = c_ST_DECODE;
                end
            end
            c_ST_DECODE: begin
                if (w_decoded_class == c_CLS_NONE) begin
                    w_set_trap   = 1'b1;
                    w_next_state = c_ST_TRAP;
                end else begin
                    w_load_class = 1'b1;
                    w_next_state = c_ST_EXEC;
                end
            end
            c_ST_EXEC: begin
                case (r_class)
                    c_CLS_B: begin
                        // Branches retire here: PC+4 or target by comparator
                        w_pc_we      = 1'b1;
                        w_pc_sel     = branch_taken;
                        w_next_state = c_ST_FETCH;
                    end
                    c_CLS_I_L, c_CLS_S: begin
                        w_next_state = c_ST_MEM;
                    end
                    c_CLS_R, c_CLS_I_C, c_CLS_LUI, c_CLS_AUIPC,
                    c_CLS_JAL, c_CLS_JALR: begin
                        w_next_state = c_ST_WB;
                    end
                    default: begin
                        w_next_state = c_ST_FETCH;
                    end
                endcase
            end
            c_ST_MEM: begin
                // Data access at the ALU-computed address
                w_mem_req  = 1'b1;
                w_addr_sel = 1'b1;
                w_mem_we   = (r_class == c_CLS_S);
                if (mem_ready) begin
                    if (r_class == c_CLS_S) begin
                        // Stores have nothing to write back; retire now
                        w_pc_we      = 1'b1;
                        w_next_state = c_ST_FETCH;
                    end else begin
                        w_next_state = c_ST_WB;
                    end
                end
            end
            c_ST_WB: begin
                w_rf_we = 1'b1;
                w_pc_we = 1'b1;
                if (r_class == c_CLS_I_L) begin
                    w_wb_sel = c_WB_MEM;
                end else if ((r_class == c_CLS_JAL) || (r_class == c_CLS_JALR)) begin
                    w_wb_sel = c_WB_PC4;
                    w_pc_sel = 1'b1;
                end
                w_next_state = c_ST_FETCH;
            end
            c_ST_TRAP: begin
                // Parked until reset with all strobes low
                w_next_state = c_ST_TRAP;
            end
            default: begin
                w_next_state = c_ST_FETCH;
            end
        endcase
    end

    // State, class, sticky trap and retire counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_FETCH;
            r_class      <= c_CLS_NONE;
            r_trap       <= 1'b0;
            r_retire_cnt <= 32'd0;
        end else begin
            r_state <= w_next_state;
            if (w_load_class) begin
                r_class <= w_decoded_class;
            end
            if (w_set_trap) begin
                r_trap <= 1'b1;
            end
            if (w_pc_we) begin
                r_retire_cnt <= r_retire_cnt + 32'd1;
            end
        end
    end

    // Outputs are held low for as long as reset is asserted, which also drops
    // any memory request that was outstanding when reset arrived
    assign mem_req    = w_mem_req  & ~rst;
    assign mem_we     = w_mem_we   & ~rst;
    assign addr_sel   = w_addr_sel & ~rst;
    assign ir_we      = w_ir_we    & ~rst;
    assign pc_we      = w_pc_we    & ~rst;
    assign pc_sel     = w_pc_sel   & ~rst;
    assign rf_we      = w_rf_we    & ~rst;
    assign wb_sel     = rst ? c_WB_ALU : w_wb_sel;
    assign state      = rst ? c_ST_FETCH : r_state;
    assign trap       = r_trap & ~rst;
    assign retire_cnt = rst ? 32'd0 : r_retire_cnt;

endmodule
`default_nettype wire
